// File: rtl/seq_mult8_pkg.sv
// seq_mult8_pkg: shared MAC widths and FSM state encodings for the multiply and accumulate stages
package seq_mult8_pkg;
    localparam int MAC_W  = 8;
    localparam int PROD_W = 16;
    localparam int CNT_W  = 3;
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;
endpackage

// File: rtl/seq_mult8_prefix8.sv
// prefix8: 8-bit Kogge-Stone prefix adder with carry-in and carry-out
module prefix8 (
    input  logic [7:0] x,
    input  logic [7:0] y,
    input  logic       c,
    output logic [7:0] s,
    output logic       cout
);
    logic [7:0] pr, g, pk;
    assign pr = x ^ y;
    // log2(8)=3 prefix levels; bit 0 generate folds in the carry-in
    always_comb begin
        g    = x & y;
        g[0] = g[0] | (pr[0] & c);
        pk   = pr;
        for (int l = 0; l < 3; l++) begin
            for (int i = 7; i >= 0; i--) begin
                if (i >= (1 << l)) begin
                    g[i]  = g[i] | (pk[i] & g[i - (1 << l)]);
                    pk[i] = pk[i] & pk[i - (1 << l)];
                end
            end
        end
    end
    assign s    = pr ^ {g[6:0], c};
    assign cout = g[7];
endmodule

// File: rtl/seq_mult8.sv
// seq_mult8: radix-2 shift-add 8x8 unsigned multiplier; EARLY_TERM_EN enables early exit on zero remaining multiplier bits
module seq_mult8
    import seq_mult8_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   prod,
    output logic                 busy
);
    if (WIDTH != 8 || CNT_W != 3) begin : g_bad_width
        $error("seq_mult8 supports only WIDTH=8, CNT_W=3");
    end

    state_e                state_q, state_d;
    logic [WIDTH-1:0]      a_q, a_d, h_q, h_d, q_q, q_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [2*WIDTH-1:0]    prod_q, prod_d;
    logic [WIDTH-1:0]      sum;
    logic                  cout;

    prefix8 u_add (
        .x    (h_q),
        .y    (q_q[0] ? a_q : '0),
        .c    (1'b0),
        .s    (sum),
        .cout (cout)
    );

`ifdef EARLY_TERM_EN
    logic [CNT_W-1:0] rem;
    logic [WIDTH-1:0] rem_mask;
    assign rem      = ~cnt_q;
    assign rem_mask = (WIDTH'(1) << rem) - WIDTH'(1);
`endif

    // next-state: accept in IDLE, one shift-add per RUN cycle, hold product in DONE
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        h_d     = h_q;
        q_d     = q_q;
        cnt_d   = cnt_q;
        prod_d  = prod_q;
        case (state_q)
            ST_IDLE: if (in_valid) begin
                a_d     = a;
                q_d     = b;
                h_d     = '0;
                cnt_d   = '0;
                state_d = ST_RUN;
`ifdef EARLY_TERM_EN
                if (b == '0) begin
                    state_d = ST_DONE;
                    prod_d  = '0;
                end
`endif
            end
            ST_RUN: begin
                h_d   = {cout, sum[WIDTH-1:1]};
                q_d   = {sum[0], q_q[WIDTH-1:1]};
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == '1) begin
                    state_d = ST_DONE;
                    prod_d  = {h_d, q_d};
                end
`ifdef EARLY_TERM_EN
                else if ((q_d & rem_mask) == '0) begin
                    state_d = ST_DONE;
                    prod_d  = {h_d, q_d} >> rem;
                end
`endif
            end
            ST_DONE: if (out_ready) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // state and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            a_q     <= '0;
            h_q     <= '0;
            q_q     <= '0;
            cnt_q   <= '0;
            prod_q  <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            h_q     <= h_d;
            q_q     <= q_d;
            cnt_q   <= cnt_d;
            prod_q  <= prod_d;
        end
    end

    assign in_ready  = state_q == ST_IDLE;
    assign out_valid = state_q == ST_DONE;
    assign busy      = state_q == ST_RUN || state_q == ST_DONE;
    assign prod      = prod_q;
endmodule

// File: tb/tb_seq_mult8.sv
// tb_seq_mult8: self-checking bench for seq_mult8 against a latency/product model
module tb_seq_mult8;
`ifdef EARLY_TERM_EN
    localparam bit ET = 1'b1;
`else
    localparam bit ET = 1'b0;
`endif
    logic        clk = 1'b0;
    logic        rst, in_valid, out_ready, in_ready, out_valid, busy;
    logic [7:0]  a, b;
    logic [15:0] prod;
    int          checks = 0, errors = 0, cyc = 0;
    bit          chk_en = 1'b0, rec = 1'b0;
    int          m_st = 0, m_rem = 0;
    logic [15:0] m_p = '0;
    int          hs_t[$];
    logic [15:0] hs_p[$];

    always #5 clk = ~clk;

    seq_mult8 dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .prod      (prod),
        .busy      (busy)
    );

    function automatic int lat_of(input logic [7:0] bv);
        int m = 0;
        for (int i = 0; i < 8; i++) if (bv[i]) m = i + 1;
        return ET ? m : 8;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", nm, act, exp, cyc);
        end
    endtask

    // model: after acceptance, DONE follows after lat_of(b) edges and holds a*b until taken
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst) begin
            m_st  <= 0;
            m_rem <= 0;
            m_p   <= '0;
        end else begin
            case (m_st)
                0: if (in_valid) begin
                    m_p   <= 16'(a) * 16'(b);
                    m_rem <= lat_of(b);
                    m_st  <= (lat_of(b) == 0) ? 2 : 1;
                end
                1: begin
                    m_rem <= m_rem - 1;
                    if (m_rem == 1) m_st <= 2;
                end
                2: if (out_ready) m_st <= 0;
                default: m_st <= 0;
            endcase
        end
    end

    always @(negedge clk) if (chk_en) begin
        chk("in_ready", 32'(in_ready), 32'(m_st == 0));
        chk("out_valid", 32'(out_valid), 32'(m_st == 2));
        chk("busy", 32'(busy), 32'(m_st != 0));
        if (m_st == 2) chk("prod", 32'(prod), 32'(m_p));
    end

    always @(negedge clk) if (rec && out_valid && out_ready) begin
        hs_t.push_back(cyc);
        hs_p.push_back(prod);
    end

    task automatic op(input logic [7:0] av, input logic [7:0] bv, input logic [15:0] exp,
                      input int lat, input int stall, input string nm);
        int n;
        @(negedge clk);
        a = av; b = bv; in_valid = 1'b1; out_ready = 1'b0;
        n = 0;
        while (!in_ready && n < 40) begin @(negedge clk); n++; end
        chk({nm, "_accept"}, 32'(in_ready), 1);
        @(negedge clk);
        in_valid = 1'b0;
        chk({nm, "_busy_in_ready"}, 32'(in_ready), 0);
        n = 0;
        while (!out_valid && n < 40) begin @(negedge clk); n++; end
        chk({nm, "_latency"}, n, lat);
        chk({nm, "_prod"}, 32'(prod), 32'(exp));
        repeat (stall) begin
            @(negedge clk);
            chk({nm, "_hold_valid"}, 32'(out_valid), 1);
            chk({nm, "_hold_prod"}, 32'(prod), 32'(exp));
            chk({nm, "_hold_in_ready"}, 32'(in_ready), 0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk({nm, "_back_idle"}, 32'(in_ready), 1);
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0]  ba [4] = '{8'h12, 8'hAB, 8'h01, 8'h7F};
        logic [7:0]  bb [4] = '{8'h81, 8'hCD, 8'hFF, 8'h80};
        logic [15:0] bp [4] = '{16'h0912, 16'h88EF, 16'h00FF, 16'h3F80};
        int idx, n;
        logic [7:0] ra, rb;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("rst_in_ready", 32'(in_ready), 1);
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_prod", 32'(prod), 0);
        chk_en = 1'b1;

        op(8'hFF, 8'hFF, 16'hFE01, 8, 0, "ff_ff");
        op(8'h0D, 8'h0B, 16'h008F, ET ? 4 : 8, 0, "0d_0b");
        op(8'h80, 8'h02, 16'h0100, ET ? 2 : 8, 0, "80_02");
        op(8'hA5, 8'h3C, 16'h26AC, ET ? 6 : 8, 5, "backpressure");
        op(8'h37, 8'h00, 16'h0000, ET ? 0 : 8, 0, "b_zero");
        op(8'h37, 8'h01, 16'h0037, ET ? 1 : 8, 0, "b_one");
        op(8'hC3, 8'h80, 16'h6180, 8, 0, "b_msb");
        op(8'h00, 8'h5A, 16'h0000, ET ? 7 : 8, 0, "a_zero");

        @(negedge clk);
        a = 8'hFF; b = 8'hFF; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_in_ready", 32'(in_ready), 1);
        chk("midrst_out_valid", 32'(out_valid), 0);
        chk("midrst_busy", 32'(busy), 0);
        chk("midrst_prod", 32'(prod), 0);
        repeat (10) begin
            @(negedge clk);
            chk("midrst_no_stale_valid", 32'(out_valid), 0);
        end
        op(8'h03, 8'h05, 16'h000F, ET ? 3 : 8, 0, "after_rst");

        hs_t.delete();
        hs_p.delete();
        @(negedge clk);
        rec = 1'b1; out_ready = 1'b1; in_valid = 1'b1; a = ba[0]; b = bb[0];
        idx = 0; n = 0;
        while (idx < 4 && n < 100) begin
            if (in_ready) begin
                @(posedge clk);
                #1;
                idx++;
                if (idx < 4) begin a = ba[idx]; b = bb[idx]; end
                else in_valid = 1'b0;
            end
            @(negedge clk);
            n++;
        end
        n = 0;
        while (hs_t.size() < 4 && n < 60) begin @(negedge clk); n++; end
        @(negedge clk);
        rec = 1'b0; out_ready = 1'b0;
        chk("b2b_count", 32'(hs_t.size()), 4);
        for (int i = 0; i < 4; i++) begin
            if (i < hs_t.size()) chk("b2b_prod", 32'(hs_p[i]), 32'(bp[i]));
            if (i > 0 && i < hs_t.size()) chk("b2b_spacing", hs_t[i] - hs_t[i-1], 10);
        end

        for (int k = 0; k < 2000; k++) begin
            ra = 8'($urandom_range(0, 255));
            rb = (k % 8 == 0) ? 8'($urandom_range(0, 7)) : 8'($urandom_range(0, 255));
            op(ra, rb, 16'(ra) * 16'(rb), lat_of(rb), $urandom_range(0, 2), "rnd");
        end

        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
